period_capture_8bit: RTL and testbench

- Measuring end of the reloadable counter path. The counter/register pair generates periodic terminal-count pulses; this block receives a pulse train and measures the clock-cycle interval between consecutive rising edges.
- Each measured interval is presented on a valid/ready output with a saturation flag.
- Typical use: loop back a counter's tc output to confirm the programmed reload period, or measure any external periodic strobe.

---
 rtl/period_capture_8bit.sv | 113 +++++++++++
 tb/tb_period_capture_8bit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/period_capture_8bit.sv
// Period capture: measures clk cycles between consecutive rising edges of event_in and
// presents each interval on a valid/ready slot with saturation and dropped-result flags.
module period_capture_8bit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             event_in,
   input  logic             arm,
   input  logic             cont,
   input  logic             abort,
   output logic [WIDTH-1:0] period_out,
   output logic             period_ovf,
   output logic             period_valid,
   input  logic             period_ready,
   output logic             missed,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StWaitFirst, StMeasure} state_t;

   localparam logic [WIDTH-1:0] CntMax = '1;
   localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

   state_t           r_state;
   logic             r_event_d;
   logic [WIDTH-1:0] r_cnt;
   logic             r_sat;
   logic [WIDTH-1:0] r_out;
   logic             r_ovf;
   logic             r_valid;
   logic             r_missed;

   logic w_edge;
   logic w_capture;
   logic w_slot_free;

   assign w_edge      = event_in & ~r_event_d;
   assign w_capture   = (r_state == StMeasure) & w_edge & ~abort;
   // The slot counts as free when the current result is being consumed this same cycle.
   assign w_slot_free = ~r_valid | period_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_event_d <= 1'b1;
         r_cnt     <= '0;
         r_sat     <= 1'b0;
         r_out     <= '0;
         r_ovf     <= 1'b0;
         r_valid   <= 1'b0;
         r_missed  <= 1'b0;
      end else begin
         r_event_d <= event_in;

         if (r_valid && period_ready) begin
            r_valid <= 1'b0;
         end
         if (w_capture) begin
            if (w_slot_free) begin
               r_out   <= r_cnt;
               r_ovf   <= r_sat;
               r_valid <= 1'b1;
            end else begin
               r_missed <= 1'b1;
            end
         end

         if (abort) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
         end else begin
            case (r_state)
               StIdle: begin
                  if (arm) begin
                     r_state <= StWaitFirst;
                  end
               end
               StWaitFirst: begin
                  if (w_edge) begin
                     r_cnt   <= CntOne;
                     r_state <= StMeasure;
                  end
               end
               StMeasure: begin
                  if (w_edge) begin
                     r_sat <= 1'b0;
                     // Continuous mode: the closing edge also opens the next interval.
                     if (cont) begin
                        r_cnt <= CntOne;
                     end else begin
                        r_state <= StIdle;
                     end
                  end else if (r_cnt == CntMax) begin
                     r_sat <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign period_out   = r_out;
   assign period_ovf   = r_ovf;
   assign period_valid = r_valid;
   assign missed       = r_missed;
   assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_period_capture_8bit.sv
// Bench for period_capture_8bit: table of single-shot intervals plus hand-written sequences,
// with a scoreboard queue popped on every valid&ready handshake.
module tb_period_capture_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       event_in;
   logic       arm;
   logic       cont;
   logic       abort;
   logic [7:0] period_out;
   logic       period_ovf;
   logic       period_valid;
   logic       period_ready;
   logic       missed;
   logic       busy;

   always #5 clk = ~clk;

   period_capture_8bit #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .event_in     (event_in),
      .arm          (arm),
      .cont         (cont),
      .abort        (abort),
      .period_out   (period_out),
      .period_ovf   (period_ovf),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .missed       (missed),
      .busy         (busy)
   );

   typedef struct {
      logic [7:0] p;
      logic       ovf;
   } exp_t;

   typedef struct {
      int         gap;
      logic [7:0] p;
      logic       ovf;
   } vec_t;

   exp_t q[$];
   vec_t vecs[9];
   int   total = 0;
   int   bad   = 0;

   function automatic void chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse();
      event_in = 1'b1;
      tick();
      event_in = 1'b0;
   endtask

   task automatic push(input logic [7:0] p, input logic o);
      exp_t e;
      e.p   = p;
      e.ovf = o;
      q.push_back(e);
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // Scoreboard: every handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && period_valid && period_ready) begin
         chk("sb_expected_pending", int'(q.size() > 0), 1);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_period", int'(period_out), int'(e.p));
            chk("sb_ovf", int'(period_ovf), int'(e.ovf));
         end
      end
   end

   initial begin
      vecs[0] = '{gap: 10,  p: 8'd10,  ovf: 1'b0};
      vecs[1] = '{gap: 2,   p: 8'd2,   ovf: 1'b0};
      vecs[2] = '{gap: 3,   p: 8'd3,   ovf: 1'b0};
      vecs[3] = '{gap: 37,  p: 8'd37,  ovf: 1'b0};
      vecs[4] = '{gap: 254, p: 8'd254, ovf: 1'b0};
      vecs[5] = '{gap: 255, p: 8'd255, ovf: 1'b0};
      vecs[6] = '{gap: 256, p: 8'd255, ovf: 1'b1};
      vecs[7] = '{gap: 300, p: 8'd255, ovf: 1'b1};
      vecs[8] = '{gap: 12,  p: 8'd12,  ovf: 1'b0};

      rst = 1'b1; event_in = 1'b0; arm = 1'b0; cont = 1'b0; abort = 1'b0; period_ready = 1'b1;
      idle(3);
      rst = 1'b0;
      chk("rst_valid", int'(period_valid), 0);
      chk("rst_missed", int'(missed), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_period", int'(period_out), 0);
      chk("rst_ovf", int'(period_ovf), 0);

      // Single-shot intervals, including the saturation boundary.
      for (int i = 0; i < 9; i++) begin
         do_arm();
         chk("vec_busy_armed", int'(busy), 1);
         idle(2);
         pulse();
         idle(vecs[i].gap - 1);
         push(vecs[i].p, vecs[i].ovf);
         pulse();
         chk("vec_valid", int'(period_valid), 1);
         tick();
         chk("vec_valid_one_cycle", int'(period_valid), 0);
         chk("vec_idle", int'(busy), 0);
      end

      // Continuous back-to-back intervals of 37 cycles.
      cont = 1'b1;
      do_arm();
      pulse();
      for (int k = 0; k < 6; k++) begin
         idle(36);
         push(8'd37, 1'b0);
         pulse();
         chk("cont_valid", int'(period_valid), 1);
         chk("cont_busy", int'(busy), 1);
      end
      do_abort();
      chk("cont_abort_idle", int'(busy), 0);
      idle(3);

      // Abort coinciding with a closing edge: no capture.
      do_arm();
      pulse();
      idle(5);
      event_in = 1'b1;
      abort    = 1'b1;
      tick();
      event_in = 1'b0;
      abort    = 1'b0;
      chk("abort_edge_valid", int'(period_valid), 0);
      chk("abort_edge_busy", int'(busy), 0);
      idle(3);
      chk("abort_edge_valid_later", int'(period_valid), 0);

      // Arm while measuring does not disturb the interval.
      cont = 1'b0;
      do_arm();
      pulse();
      idle(3);
      do_arm();
      idle(5);
      push(8'd10, 1'b0);
      pulse();
      chk("arm_busy_valid", int'(period_valid), 1);
      tick();

      // event_in held high across reset release is not an edge.
      event_in = 1'b1;
      rst      = 1'b1;
      idle(2);
      rst = 1'b0;
      do_arm();
      idle(3);
      chk("hi_rst_waiting", int'(busy), 1);
      chk("hi_rst_no_valid", int'(period_valid), 0);
      event_in = 1'b0;
      idle(2);
      pulse();
      idle(7);
      push(8'd8, 1'b0);
      pulse();
      chk("hi_rst_valid", int'(period_valid), 1);
      tick();

      // Back-pressure: first result held, later captures dropped and flagged.
      period_ready = 1'b0;
      cont         = 1'b1;
      do_arm();
      pulse();
      idle(4);
      push(8'd5, 1'b0);
      pulse();
      chk("bp_valid", int'(period_valid), 1);
      chk("bp_period", int'(period_out), 5);
      chk("bp_missed_clear", int'(missed), 0);
      idle(4);
      pulse();
      chk("bp_missed_set", int'(missed), 1);
      chk("bp_hold", int'(period_out), 5);
      chk("bp_hold_valid", int'(period_valid), 1);
      idle(4);
      pulse();
      chk("bp_hold2", int'(period_out), 5);
      idle(3);
      period_ready = 1'b1;
      tick();
      chk("bp_consumed", int'(period_valid), 0);
      push(8'd5, 1'b0);
      pulse();
      chk("bp_next_valid", int'(period_valid), 1);
      chk("bp_missed_sticky", int'(missed), 1);
      tick();
      chk("bp_next_consumed", int'(period_valid), 0);
      do_abort();
      chk("bp_abort_keeps_missed", int'(missed), 1);

      // Reset while a result is pending and measurement is running.
      period_ready = 1'b0;
      do_arm();
      pulse();
      idle(4);
      pulse();
      chk("mid_valid", int'(period_valid), 1);
      chk("mid_period", int'(period_out), 5);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", int'(period_valid), 0);
      chk("mid_rst_missed", int'(missed), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_period", int'(period_out), 0);
      rst          = 1'b0;
      period_ready = 1'b1;
      idle(3);
      chk("mid_rst_no_valid", int'(period_valid), 0);

      chk("sb_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
